// File: rtl/rr_mux_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_pkg
//   Shared definitions for the round-robin / fixed-priority mux arbiter.
//   Holds only width-independent types so every instance, whatever its
//   channel count or data width, can import the same package.
//
//   Contents:
//     arb_mode_t  arbitration policy selector
//                   ARB_FIXED : lowest requesting index always wins
//                   ARB_RR    : rotating priority starting at the saved pointer
// ---------------------------------------------------------------------------
package rr_mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// ---------------------------------------------------------------------------
// mux2 / mux_n
//   mux2  : plain W-bit 2:1 multiplexer, the leaf cell of the tree.
//   mux_n : N-to-1 word selector driven by a one-hot select. The one-hot
//           select is folded to a binary index and then steers a balanced
//           tree of mux2 cells, one index bit per tree level.
//
//   mux2 ports:
//     d0_i   in  W    word chosen when sel_i = 0
//     d1_i   in  W    word chosen when sel_i = 1
//     sel_i  in  1    select
//     y_o    out W    selected word
//
//   mux_n ports:
//     data_i in  N*W  word i occupies bits [i*W +: W]
//     sel_i  in  N    one-hot (or zero) select
//     data_o out W    selected word; word 0 when sel_i is zero
// ---------------------------------------------------------------------------
module mux2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

module mux_n #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N*W-1:0] data_i,
  input  logic [N-1:0]   sel_i,
  output logic [W-1:0]   data_o
);

  // The tree is padded up to a power of two; unused leaves are tied to zero
  // and can never be selected because their one-hot bit does not exist.
  localparam int SEL_W  = (N > 1) ? $clog2(N) : 1;
  localparam int LEAVES = 1 << SEL_W;

  logic [SEL_W-1:0] selIdx;

  // One-hot to binary: OR together the indices of all set bits. With a legal
  // one-hot input exactly one index survives.
  always_comb begin
    selIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i[i]) begin
        selIdx = selIdx | SEL_W'(i);
      end
    end
  end

  // Level 0 is the root, level SEL_W holds the leaves. Each level halves the
  // word count using one index bit, most significant bit at the root.
  for (genvar lv = 0; lv <= SEL_W; lv++) begin : g_lvl
    logic [W-1:0] v [1 << lv];

    if (lv == SEL_W) begin : g_leaf
      for (genvar i = 0; i < LEAVES; i++) begin : g_word
        if (i < N) begin : g_real
          assign v[i] = data_i[i*W +: W];
        end else begin : g_pad
          assign v[i] = '0;
        end
      end
    end else begin : g_node
      for (genvar j = 0; j < (1 << lv); j++) begin : g_mux
        mux2 #(.W(W)) u_mux2 (
          .d0_i  (g_lvl[lv+1].v[2*j]),
          .d1_i  (g_lvl[lv+1].v[2*j+1]),
          .sel_i (selIdx[SEL_W-1-lv]),
          .y_o   (v[j])
        );
      end
    end
  end

  assign data_o = g_lvl[0].v[0];

endmodule

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//   N_CH-channel, W-bit data selector with valid/ready handshakes on both
//   sides. Each cycle one requesting channel is chosen (fixed priority or
//   round-robin) and its word is captured into a registered output stage.
//   Throughput is one word per cycle; a word appears on the output one cycle
//   after its channel sees in_ready.
//
//   Ports:
//     clk        in   1        clock, rising edge
//     rst        in   1        synchronous active-high reset
//     in_valid   in   N_CH     per-channel request
//     in_data    in   N_CH*W   channel i at bits [i*W +: W]
//     in_ready   out  N_CH     one-hot or zero; channel i accepted this cycle
//     out_valid  out  1        output register holds a word
//     out_data   out  W        held word
//     out_ch     out  CH_W     channel that supplied out_data
//     out_ready  in   1        consumer takes the word when out_valid is high
// ---------------------------------------------------------------------------
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  parameter  int MODE = 1,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [CH_W-1:0]   out_ch,
  input  logic              out_ready
);

  // The pointer only matters for round-robin with more than one channel;
  // otherwise the search always starts at channel 0 and the pointer stays 0.
  localparam bit RR_EN = (MODE == int'(ARB_RR)) && (N_CH > 1);

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              outValid_q, outValid_d;
  logic [W-1:0]      outData_q, outData_d;
  logic [CH_W-1:0]   outCh_q, outCh_d;

  logic [CH_W-1:0]   base;
  logic [2*N_CH-1:0] reqDoubled;
  logic [N_CH-1:0]   reqRot;
  logic              found;
  logic [CH_W-1:0]   rotOff;
  logic [CH_W:0]     idxSum;
  logic [CH_W-1:0]   grantIdx;
  logic [N_CH-1:0]   grant;
  logic [W-1:0]      selData;
  logic              load;

  // Grant search: rotate the request vector so the starting channel sits at
  // bit 0, take the lowest set bit, then add the rotation back modulo N_CH.
  // Doubling the vector lets a plain part-select perform the rotation for
  // any N_CH, power of two or not.
  always_comb begin
    base       = RR_EN ? ptr_q : '0;
    reqDoubled = {in_valid, in_valid};
    reqRot     = reqDoubled[base +: N_CH];
    found      = 1'b0;
    rotOff     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && reqRot[i]) begin
        found  = 1'b1;
        rotOff = CH_W'(i);
      end
    end
    idxSum = {1'b0, base} + {1'b0, rotOff};
    if (idxSum >= (CH_W+1)'(N_CH)) begin
      idxSum = idxSum - (CH_W+1)'(N_CH);
    end
    grantIdx = idxSum[CH_W-1:0];
    grant    = found ? (N_CH'(1) << grantIdx) : '0;
  end

  mux_n #(
    .N (N_CH),
    .W (W)
  ) u_mux_n (
    .data_i (in_data),
    .sel_i  (grant),
    .data_o (selData)
  );

  // The output register can take a new word when it is empty or being
  // drained this same cycle; reset blocks every transfer.
  assign load     = ~rst & (~outValid_q | out_ready) & (|in_valid);
  assign in_ready = load ? grant : '0;

  // Next-state for the output stage and pointer. A drain with nothing to
  // refill clears valid but leaves data and channel untouched. The pointer
  // moves to one past the winner only when a word actually transfers.
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outCh_d    = outCh_q;
    ptr_d      = ptr_q;
    if (load) begin
      outValid_d = 1'b1;
      outData_d  = selData;
      outCh_d    = grantIdx;
      if (RR_EN) begin
        ptr_d = (grantIdx == CH_W'(N_CH - 1)) ? '0 : grantIdx + CH_W'(1);
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers; reset discards any held word and restarts the rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outCh_q    <= '0;
      ptr_q      <= '0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outCh_q    <= outCh_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_ch    = outCh_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
//   Drives four arbiter instances from one shared stimulus stream:
//     dut0 : N_CH=4, MODE=1 (round-robin)
//     dut1 : N_CH=4, MODE=0 (fixed priority)
//     dut2 : N_CH=3, MODE=1 (non-power-of-two)
//     dut3 : N_CH=1, MODE=1
//   A per-instance reference model predicts in_ready each cycle and pushes
//   the word it expects into a queue; words are popped as they leave.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  inValid;
  logic [31:0] inData;
  logic        outReady;

  logic [3:0]  rdyA, rdyB;
  logic [2:0]  rdyC;
  logic [0:0]  rdyD;
  logic        ovA, ovB, ovC, ovD;
  logic [7:0]  dataA, dataB, dataC, dataD;
  logic [1:0]  chA, chB, chC;
  logic [0:0]  chD;

  int checkCount = 0;
  int errorCount = 0;
  bit sbOn = 1'b0;

  int          ptrM  [4];
  logic [7:0]  lastD [4];
  int          lastC [4];
  int          sb    [4][$];

  rr_mux_arbiter #(.N_CH(4), .W(8), .MODE(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData),
    .in_ready(rdyA), .out_valid(ovA), .out_data(dataA), .out_ch(chA),
    .out_ready(outReady));

  rr_mux_arbiter #(.N_CH(4), .W(8), .MODE(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData),
    .in_ready(rdyB), .out_valid(ovB), .out_data(dataB), .out_ch(chB),
    .out_ready(outReady));

  rr_mux_arbiter #(.N_CH(3), .W(8), .MODE(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid[2:0]), .in_data(inData[23:0]),
    .in_ready(rdyC), .out_valid(ovC), .out_data(dataC), .out_ch(chC),
    .out_ready(outReady));

  rr_mux_arbiter #(.N_CH(1), .W(8), .MODE(1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(inValid[0:0]), .in_data(inData[7:0]),
    .in_ready(rdyD), .out_valid(ovD), .out_data(dataD), .out_ch(chD),
    .out_ready(outReady));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model for one instance, evaluated mid-cycle before the edge:
  // compare the current output stage, predict in_ready, then advance the
  // model to what the coming edge should produce.
  task automatic scoreboardStep(input int k, input int n, input bit rr,
                                input logic [3:0] rdyObs, input logic ovObs,
                                input logic [7:0] dObs, input logic [1:0] chObs);
    logic [3:0] req;
    int         g;
    int         base;
    int         idx;
    int         entry;
    bit         load;
    req = inValid & ((4'd1 << n) - 4'd1);
    checkOutput($sformatf("dut%0d_out_valid", k), 32'(ovObs), 32'(sb[k].size() > 0));
    if (sb[k].size() > 0) begin
      entry = sb[k][0];
      checkOutput($sformatf("dut%0d_out_data", k), 32'(dObs), 32'(entry >> 8));
      checkOutput($sformatf("dut%0d_out_ch", k), 32'(chObs), 32'(entry & 255));
    end else begin
      checkOutput($sformatf("dut%0d_idle_data", k), 32'(dObs), 32'(lastD[k]));
      checkOutput($sformatf("dut%0d_idle_ch", k), 32'(chObs), 32'(lastC[k]));
    end
    load = !rst && (sb[k].size() == 0 || outReady) && (req != 4'd0);
    base = rr ? ptrM[k] : 0;
    g = -1;
    for (int off = 0; off < n; off++) begin
      idx = (base + off) % n;
      if (g < 0 && req[idx]) g = idx;
    end
    checkOutput($sformatf("dut%0d_in_ready", k), 32'(rdyObs), load ? 32'(1 << g) : 32'd0);
    if (rst) begin
      sb[k].delete();
      lastD[k] = 8'h00;
      lastC[k] = 0;
      ptrM[k]  = 0;
    end else begin
      if (sb[k].size() > 0 && outReady) begin
        entry    = sb[k].pop_front();
        lastD[k] = 8'(entry >> 8);
        lastC[k] = entry & 255;
      end
      if (load) begin
        sb[k].push_back((int'(inData[g*8 +: 8]) << 8) | g);
        if (rr) ptrM[k] = (g + 1) % n;
      end
    end
  endtask

  // Mid-cycle monitor: inputs were driven just after the previous edge.
  always @(negedge clk) begin
    if (sbOn) begin
      scoreboardStep(0, 4, 1'b1, rdyA, ovA, dataA, chA);
      scoreboardStep(1, 4, 1'b0, rdyB, ovB, dataB, chB);
      scoreboardStep(2, 3, 1'b1, {1'b0, rdyC}, ovC, dataC, chC);
      scoreboardStep(3, 1, 1'b1, {3'b000, rdyD}, ovD, dataD, {1'b0, chD});
    end
  end

  // Drive the control inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic [3:0] v, input logic r, input logic rs);
    inValid  = v;
    outReady = r;
    rst      = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expSeqA [6] = '{0, 1, 2, 3, 0, 1};
    int expSeqC [6] = '{0, 1, 2, 0, 1, 2};
    inData = 32'h4433_2211;
    applyStimulus(4'b1111, 1'b1, 1'b1);
    tick();
    sbOn = 1'b1;

    // Reset held a second cycle with every channel requesting.
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checkOutput("rst_in_ready", 32'(rdyA), 32'd0);
    tick();
    checkOutput("rst_out_valid", 32'(ovA), 32'd0);
    checkOutput("rst_out_data", 32'(dataA), 32'd0);
    checkOutput("rst_out_ch", 32'(chA), 32'd0);

    // Single request on channel 2.
    inData[23:16] = 8'hA5;
    applyStimulus(4'b0100, 1'b1, 1'b0);
    checkOutput("single_in_ready", 32'(rdyA), 32'h4);
    tick();
    checkOutput("single_out_valid", 32'(ovA), 32'd1);
    checkOutput("single_out_data", 32'(dataA), 32'hA5);
    checkOutput("single_out_ch", 32'(chA), 32'd2);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick();

    // All channels requesting from a fresh pointer.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    tick();
    inData = 32'h1312_1110;
    applyStimulus(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("rr_seq%0d_ch", i), 32'(chA), 32'(expSeqA[i]));
      checkOutput($sformatf("rr_seq%0d_valid", i), 32'(ovA), 32'd1);
      checkOutput($sformatf("fixed_seq%0d_ch", i), 32'(chB), 32'd0);
      checkOutput($sformatf("n3_seq%0d_ch", i), 32'(chC), 32'(expSeqC[i]));
      checkOutput($sformatf("n1_seq%0d_ch", i), 32'(chD), 32'd0);
    end

    // Backpressure: output holds channel 1, pointer parked at 2.
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("stall_in_ready", 32'(rdyA), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall%0d_ch", i), 32'(chA), 32'd1);
      checkOutput($sformatf("stall%0d_data", i), 32'(dataA), 32'h11);
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("resume_in_ready", 32'(rdyA), 32'h4);
    tick();
    checkOutput("resume_ch", 32'(chA), 32'd2);

    // Wrap and skip around the pointer.
    applyStimulus(4'b0000, 1'b1, 1'b1);
    tick();
    applyStimulus(4'b0100, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("skip_in_ready", 32'(rdyA), 32'h2);
    tick();
    checkOutput("skip_ch", 32'(chA), 32'd1);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b1000, 1'b1, 1'b0);
    checkOutput("wrap_in_ready", 32'(rdyA), 32'h8);
    tick();
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("wrap_ptr0_in_ready", 32'(rdyA), 32'h1);
    tick();

    // Mid-stream reset while a word is stalled at the output.
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick();
    inData[7:0] = 8'h5A;
    applyStimulus(4'b0001, 1'b0, 1'b0);
    tick();
    checkOutput("held_out_valid", 32'(ovA), 32'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("midrst_out_valid", 32'(ovA), 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("midrst_no_delivery", 32'(ovA), 32'd0);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("midrst_ptr0_in_ready", 32'(rdyA), 32'h1);
    tick();

    // Random traffic, checked by the scoreboard alone.
    for (int i = 0; i < 300; i++) begin
      inData = $urandom;
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 49) == 0));
      tick();
    end

    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
